// File: rtl/rr_arbiter_4to1_if.sv
// Shared-channel bundle between four requesters and the round-robin arbiter.
// The master modport is the arbiter side; slave is the requester/consumer side.
interface rr_arbiter_4to1_if #(
  parameter int DW = 8
);
  logic [3:0]      req;
  logic [4*DW-1:0] in_data;
  logic            out_ready;
  logic [3:0]      gnt;
  logic [1:0]      sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            busy;

  modport master (
    input  req,
    input  in_data,
    input  out_ready,
    output gnt,
    output sel,
    output out_valid,
    output out_data,
    output busy
  );

  modport slave (
    output req,
    output in_data,
    output out_ready,
    input  gnt,
    input  sel,
    input  out_valid,
    input  out_data,
    input  busy
  );
endinterface

// File: rtl/rr_arbiter_4to1.sv
// Round-robin 4:1 arbiter with bounded hold per grant; gnt rises one clock after req.
// Backpressure: out_ready=0 stalls the current grant indefinitely, beats only count on valid&&ready.
module rr_arbiter_4to1 #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rr_arbiter_4to1_if.master  bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    last_q, last_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [HW-1:0] hold_cnt, hold_d;

  logic          busy;
  logic          out_valid;
  logic          beat;
  logic          rel_drop;
  logic          rel_hold;
  logic          release_now;
  logic [1:0]    arb_base;
  logic [2:0]    pick;

  // Returns {found, index}: first set bit scanning last+1, last+2, ... with last itself scanned last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] s);
    logic [3:0] d;
    d = 4'b0000;
    d[s] = 1'b1;
    return d;
  endfunction

  assign busy        = (state == GRANT);
  assign out_valid   = busy && bus.req[sel_q];
  assign beat        = out_valid && bus.out_ready;
  assign rel_drop    = busy && !bus.req[sel_q];
  assign rel_hold    = beat && (hold_cnt == HOLD_LAST);
  assign release_now = rel_drop || rel_hold;

  // On release the old owner becomes "last", so it is only re-picked when nobody else asks.
  assign arb_base = busy ? sel_q : last_q;
  assign pick     = rr_pick(bus.req, arb_base);

  always_comb begin
    state_d = state;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_d = GRANT;
          sel_d   = pick[1:0];
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          last_d = sel_q;
          if (pick[2]) begin
            sel_d  = pick[1:0];
            hold_d = '0;
          end else begin
            state_d = IDLE;
            hold_d  = '0;
          end
        end else if (beat) begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
    gnt_d = (state_d == GRANT) ? decode(sel_d) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= 2'd0;
      last_q   <= 2'd3;
      gnt_q    <= 4'b0000;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      hold_cnt <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = busy ? bus.in_data[int'(sel_q)*DW +: DW] : '0;

endmodule
